keyboard_tracker: RTL and testbench
===================================

KEYBOARD_TRACKER -- requirements
Module: keyboard_tracker

Interface
REQ-001 SHALL have parameter PULSE_OR_HOLD, default 0, selecting output mode: 0 = hold (level while key down), 1 = pulse (one cycle per press).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, giving the PS2_CLK idle time in clock cycles after which a partial frame is discarded.
REQ-003 SHALL have port clock, input, 1 bit: the single system clock (50 MHz); all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port PS2_CLK, inout, 1 bit: PS/2 clock line from the keyboard.
REQ-006 SHALL have port PS2_DAT, inout, 1 bit: PS/2 data line from the keyboard.
REQ-007 SHALL have outputs w, a, s, d, each 1 bit: letter key states.
REQ-008 SHALL have outputs left, right, up, down, each 1 bit: arrow key states.
REQ-009 SHALL have outputs space and enter, each 1 bit: Space and Enter key states.

Function
REQ-010 SHALL drive PS2_CLK and PS2_DAT to high-impedance at all times; the block is receive-only.
REQ-011 SHALL synchronise PS2_CLK and PS2_DAT through two flops each before any use.
REQ-012 SHALL sample data on each synchronised PS2_CLK falling edge, shifting an 11-bit frame: start 0, 8 data bits LSB first, odd parity, stop 1.
REQ-013 SHALL validate a frame after the 11th bit as start = 0, stop = 1, and odd parity; an invalid frame is discarded with no state change.
REQ-014 SHALL clear the bit counter when no falling edge occurs for TIMEOUT_CYCLES consecutive cycles during a frame.
REQ-015 SHALL decode scan code set 2 with prefix flags: E0 sets the extended flag and F0 sets the break flag; both clear after the next non-prefix byte.
REQ-016 SHALL use these key codes:
- non-extended: w = 1D, a = 1C, s = 1B, d = 23, space = 29, enter = 5A
- extended (E0): up = 75, down = 72, left = 6B, right = 74, enter = 5A (keypad Enter)
REQ-017 SHALL ignore codes not listed in REQ-016, and extended codes whose non-extended meaning differs.
REQ-018 SHALL, in hold mode, set a key's output on its make code and clear it on its break code, one cycle after the frame's final falling edge.
REQ-019 SHALL, in pulse mode, assert a key's output for exactly one clock cycle on a make code when the key's internal held bit is 0.
REQ-020 SHALL, in pulse mode, not pulse on typematic repeat makes while the key is held; a break clears the held bit.
REQ-021 SHALL allow multiple keys to be held simultaneously and track each independently.
REQ-022 SHALL ignore a break code for a key that is not held.

Reset
REQ-023 SHALL, while reset = 0, clear all outputs, held bits, prefix flags, the shift register, the bit counter and the timeout counter.
REQ-024 SHALL resume frame reception on the first falling edge after release when reset is deasserted mid-frame; the partial frame is lost.

Configuration
REQ-025 SHALL implement REQ-013 parity and stop checking when macro KEYBOARD_TRACKER_PARITY_CHECK_EN is defined.
REQ-026 SHALL, without KEYBOARD_TRACKER_PARITY_CHECK_EN, check only the start bit and accept any parity and stop value.

Verification
REQ-027 SHALL cover hold mode: frames 1C, then F0 1C -> a = 1 after the first frame and a = 0 after the second; other outputs stay 0.
REQ-028 SHALL cover an extended key: frames E0 75, then E0 F0 75 -> up rises then falls; w and s stay 0.
REQ-029 SHALL cover pulse mode with typematic repeat: frames 5A 5A 5A, then F0 5A -> enter is high exactly 1 cycle in total.
REQ-030 SHALL cover a parity error with the macro defined: frame 1D with even parity -> w stays 0; without the macro -> w = 1.
REQ-031 SHALL cover timeout: 5 bits sent, idle > 50000 cycles, then a valid 23 frame -> d = 1.
REQ-032 SHALL cover mid-hold reset: hold space and d, pulse reset low -> all outputs read 0 immediately, asynchronously.

Source files
------------

// File: rtl/keyboard_tracker.sv
// keyboard_tracker
//   Receive-only PS/2 keyboard decoder. It reports the state of ten keys
//   (W A S D, the four arrows, Space, Enter) from scan code set 2.
//
//   Parameters
//     PULSE_OR_HOLD   0 = hold mode: an output stays high while its key is down
//                     1 = pulse mode: one-cycle pulse per fresh press
//     TIMEOUT_CYCLES  PS2_CLK idle cycles after which a partial frame is dropped
//
//   Ports
//     clock           system clock, rising edge
//     reset           asynchronous, active-low
//     PS2_CLK         PS/2 clock line, never driven (always high-impedance)
//     PS2_DAT         PS/2 data line, never driven (always high-impedance)
//     w a s d         letter key outputs
//     left right up down  arrow key outputs
//     space enter     Space, and Enter (main or keypad)
//
//   Build option
//     KEYBOARD_TRACKER_PARITY_CHECK_EN  when defined, a frame must also have
//     odd parity and stop = 1. Otherwise only the start bit is checked.
module keyboard_tracker #(
   parameter int PULSE_OR_HOLD  = 0,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic clock,
   input  logic reset,
   inout  wire  PS2_CLK,
   inout  wire  PS2_DAT,
   output logic w,
   output logic a,
   output logic s,
   output logic d,
   output logic left,
   output logic right,
   output logic up,
   output logic down,
   output logic space,
   output logic enter
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   assign PS2_CLK = 1'bz;
   assign PS2_DAT = 1'bz;

   // clk_sync[1:0] is the two-flop synchroniser; clk_sync[2] holds the
   // previous synchronised value for falling-edge detection.
   logic [2:0]    clk_sync;
   logic [1:0]    dat_sync;
   logic [9:0]    shift_reg;
   logic [3:0]    bit_cnt;
   logic [TW-1:0] tmo_cnt;
   logic          ext_flag;
   logic          brk_flag;
   logic [9:0]    held;
   logic [9:0]    pulse_q;
   logic [9:0]    key_sel;
   logic [9:0]    keys;

   logic          ps2_fall;
   logic          ps2_dat;
   logic [10:0]   frame;
   logic [7:0]    data;
   logic          frame_done;
   logic          frame_ok;

   assign ps2_fall   = clk_sync[2] & ~clk_sync[1];
   assign ps2_dat    = dat_sync[1];
   // Bit 0 is the start bit, once the incoming bit is appended as bit 10.
   assign frame      = {ps2_dat, shift_reg};
   assign data       = frame[8:1];
   assign frame_done = ps2_fall & (bit_cnt == 4'd10);

`ifdef KEYBOARD_TRACKER_PARITY_CHECK_EN
   assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);
`else
   logic unused_par_stop;
   assign unused_par_stop = ^frame[10:9];
   assign frame_ok = ~frame[0];
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         clk_sync <= '0;
         dat_sync <= '0;
      end else begin
         clk_sync <= {clk_sync[1:0], PS2_CLK};
         dat_sync <= {dat_sync[0], PS2_DAT};
      end
   end

   // Frame assembly. The timeout down-counter reloads on every falling edge.
   // It only runs while a frame is partly received.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
         tmo_cnt   <= '0;
      end else if (ps2_fall) begin
         shift_reg <= {ps2_dat, shift_reg[9:1]};
         bit_cnt   <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
         tmo_cnt   <= TW'(TIMEOUT_CYCLES - 1);
      end else if (bit_cnt != 4'd0) begin
         if (tmo_cnt == '0)
            bit_cnt <= '0;
         else
            tmo_cnt <= tmo_cnt - 1'b1;
      end
   end

   // key bit order: 0 w, 1 a, 2 s, 3 d, 4 left, 5 right, 6 up, 7 down, 8 space, 9 enter
   always_comb begin
      key_sel = '0;
      case ({ext_flag, data})
         9'h01D: key_sel[0] = 1'b1;
         9'h01C: key_sel[1] = 1'b1;
         9'h01B: key_sel[2] = 1'b1;
         9'h023: key_sel[3] = 1'b1;
         9'h029: key_sel[8] = 1'b1;
         9'h05A: key_sel[9] = 1'b1;
         9'h16B: key_sel[4] = 1'b1;
         9'h174: key_sel[5] = 1'b1;
         9'h175: key_sel[6] = 1'b1;
         9'h172: key_sel[7] = 1'b1;
         9'h15A: key_sel[9] = 1'b1;
         default: key_sel = '0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ext_flag <= 1'b0;
         brk_flag <= 1'b0;
         held     <= '0;
         pulse_q  <= '0;
      end else begin
         pulse_q <= '0;
         if (frame_done && frame_ok) begin
            if (data == 8'hE0) begin
               ext_flag <= 1'b1;
            end else if (data == 8'hF0) begin
               brk_flag <= 1'b1;
            end else begin
               ext_flag <= 1'b0;
               brk_flag <= 1'b0;
               if (brk_flag) begin
                  held <= held & ~key_sel;
               end else begin
                  held    <= held | key_sel;
                  // A typematic repeat finds its held bit already set, so it does not pulse.
                  pulse_q <= key_sel & ~held;
               end
            end
         end
      end
   end

   assign keys  = (PULSE_OR_HOLD != 0) ? pulse_q : held;

   assign w     = keys[0];
   assign a     = keys[1];
   assign s     = keys[2];
   assign d     = keys[3];
   assign left  = keys[4];
   assign right = keys[5];
   assign up    = keys[6];
   assign down  = keys[7];
   assign space = keys[8];
   assign enter = keys[9];

endmodule

// File: tb/tb_keyboard_tracker.sv
// Directed bench for keyboard_tracker. It runs one hold-mode instance and one
// pulse-mode instance side by side on the same PS/2 lines.
module tb_keyboard_tracker;

   localparam logic [9:0] K_W     = 10'b00_0000_0001;
   localparam logic [9:0] K_A     = 10'b00_0000_0010;
   localparam logic [9:0] K_S     = 10'b00_0000_0100;
   localparam logic [9:0] K_D     = 10'b00_0000_1000;
   localparam logic [9:0] K_RIGHT = 10'b00_0010_0000;
   localparam logic [9:0] K_UP    = 10'b00_0100_0000;
   localparam logic [9:0] K_SPACE = 10'b01_0000_0000;
   localparam logic [9:0] K_ENTER = 10'b10_0000_0000;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic clk_drv = 1'b1;
   logic dat_drv = 1'b1;
   wire  ps2_clk;
   wire  ps2_dat;
   logic [9:0] hk;
   logic [9:0] pk;
   int   checks = 0;
   int   errors = 0;
   int   pcnt [10] = '{default: 0};

   assign ps2_clk = clk_drv;
   assign ps2_dat = dat_drv;

   always #10 clock = ~clock;

   keyboard_tracker #(.PULSE_OR_HOLD(0)) u_hold (
      .clock(clock), .reset(reset), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
      .w(hk[0]), .a(hk[1]), .s(hk[2]), .d(hk[3]),
      .left(hk[4]), .right(hk[5]), .up(hk[6]), .down(hk[7]),
      .space(hk[8]), .enter(hk[9]));

   keyboard_tracker #(.PULSE_OR_HOLD(1)) u_pulse (
      .clock(clock), .reset(reset), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
      .w(pk[0]), .a(pk[1]), .s(pk[2]), .d(pk[3]),
      .left(pk[4]), .right(pk[5]), .up(pk[6]), .down(pk[7]),
      .space(pk[8]), .enter(pk[9]));

   // Counts every cycle in which each pulse-mode output is high.
   always @(negedge clock) begin
      for (int i = 0; i < 10; i++)
         if (pk[i] === 1'b1) pcnt[i]++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send_bit(input logic b);
      dat_drv = b;
      wait_clk(8);
      clk_drv = 1'b0;
      wait_clk(8);
      clk_drv = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] code, input logic bad_par = 1'b0);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(code[i]);
      send_bit(~(^code) ^ bad_par);
      send_bit(1'b1);
      dat_drv = 1'b1;
      wait_clk(20);
   endtask

   initial begin
      wait_clk(5);
      check("rst_hold", {22'd0, hk}, 32'd0);
      check("rst_pulse", {22'd0, pk}, 32'd0);
      reset = 1'b1;
      wait_clk(5);

      send_frame(8'h1C);
      check("hold_a_make", {22'd0, hk}, {22'd0, K_A});
      check("pulse_a_once", pcnt[1], 1);
      send_frame(8'hF0); send_frame(8'h1C);
      check("hold_a_break", {22'd0, hk}, 32'd0);
      check("pulse_a_no_break_pulse", pcnt[1], 1);

      send_frame(8'hE0); send_frame(8'h75);
      check("hold_up_make", {22'd0, hk}, {22'd0, K_UP});
      send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
      check("hold_up_break", {22'd0, hk}, 32'd0);
      check("pulse_up_once", pcnt[6], 1);
      check("pulse_w_s_quiet", pcnt[0] + pcnt[2], 0);

      send_frame(8'h5A); send_frame(8'h5A); send_frame(8'h5A);
      check("hold_enter_typematic", {22'd0, hk}, {22'd0, K_ENTER});
      send_frame(8'hF0); send_frame(8'h5A);
      check("hold_enter_break", {22'd0, hk}, 32'd0);
      check("pulse_enter_typematic", pcnt[9], 1);
      send_frame(8'h5A);
      check("pulse_enter_repress", pcnt[9], 2);
      send_frame(8'hF0); send_frame(8'h5A);

      send_frame(8'hF0); send_frame(8'h1B);
      check("break_not_held", {22'd0, hk}, 32'd0);
      send_frame(8'h1B);
      check("brk_flag_cleared", {22'd0, hk}, {22'd0, K_S});
      send_frame(8'hF0); send_frame(8'h1B);

      send_frame(8'hE0); send_frame(8'h1D);
      check("ext_1d_ignored", {22'd0, hk}, 32'd0);
      check("ext_1d_no_pulse", pcnt[0], 0);
      send_frame(8'hE0); send_frame(8'h5A);
      check("keypad_enter", {22'd0, hk}, {22'd0, K_ENTER});
      send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h5A);
      send_frame(8'h15);
      check("unknown_code", {22'd0, hk}, 32'd0);

      send_frame(8'h1D); send_frame(8'h1C); send_frame(8'hE0); send_frame(8'h74);
      check("multi_hold", {22'd0, hk}, {22'd0, K_W | K_A | K_RIGHT});
      send_frame(8'hF0); send_frame(8'h1D);
      check("multi_release_w", {22'd0, hk}, {22'd0, K_A | K_RIGHT});
      send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h74);
      send_frame(8'hF0); send_frame(8'h1C);
      check("multi_all_up", {22'd0, hk}, 32'd0);

      send_frame(8'h1D, 1'b1);
`ifdef KEYBOARD_TRACKER_PARITY_CHECK_EN
      check("parity_error", {22'd0, hk}, 32'd0);
`else
      check("parity_ignored", {22'd0, hk}, {22'd0, K_W});
`endif
      send_frame(8'hF0); send_frame(8'h1D);

      for (int i = 0; i < 5; i++) send_bit(1'b0);
      dat_drv = 1'b1;
      wait_clk(50010);
      send_frame(8'h23);
      check("timeout_recovery", {22'd0, hk}, {22'd0, K_D});
      send_frame(8'hF0); send_frame(8'h23);

      for (int i = 0; i < 3; i++) send_bit(1'b0);
      reset = 1'b0;
      wait_clk(2);
      reset = 1'b1;
      wait_clk(2);
      send_frame(8'h1B);
      check("reset_mid_frame", {22'd0, hk}, {22'd0, K_S});
      send_frame(8'hF0); send_frame(8'h1B);

      send_frame(8'h29); send_frame(8'h23);
      check("hold_space_d", {22'd0, hk}, {22'd0, K_SPACE | K_D});
      check("pulse_d_count", pcnt[3], 2);
      #3;
      reset = 1'b0;
      #1;
      check("async_reset_hold", {22'd0, hk}, 32'd0);
      check("async_reset_pulse", {22'd0, pk}, 32'd0);
      wait_clk(2);
      reset = 1'b1;
      wait_clk(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
